serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 108 ++++++++++
 tb/tb_serial_frame_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits LSB first, even parity, stop bit.
// Completed words sit in a one-entry valid/ready output buffer.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_perr,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              operr_q, operr_d;
  logic              fe_q, fe_d;
  logic              ov_q, ov_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    data_d    = data_q;
    // An accepted word frees the buffer unless a commit reloads it below.
    valid_d   = valid_q & ~out_ready;
    operr_d   = operr_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (serial_in) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        shift_d[bit_cnt_q] = serial_in;
        bit_cnt_d          = bit_cnt_q + CW'(1);
        if (bit_cnt_q == LAST) state_d = S_PARITY;
      end
      S_PARITY: begin
        perr_d  = (^shift_q) ^ serial_in;
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (serial_in) begin
          fe_d = 1'b1;
        end else if (!valid_q || out_ready) begin
          data_d  = shift_q;
          operr_d = perr_q;
          valid_d = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      operr_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      operr_q   <= operr_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_perr  = operr_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frames are built from the data word, and a one-entry
// buffer model predicts the outputs after every clock edge.
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_perr, frame_err, overrun, busy;

  int checks = 0;
  int failures = 0;

  // Reference buffer: what the consumer should currently see.
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_perr  = 1'b0;

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_perr(out_perr),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock: drive, update the model for this edge, compare just after the edge.
  // commit: 0 = no frame end, 1 = good stop bit, 2 = bad stop bit.
  task automatic tick(input logic sin, input logic rdy, input int commit,
                      input logic [7:0] word, input logic pe, input logic exp_busy,
                      input string nm);
    bit exp_fe, exp_ov;
    @(negedge clk);
    serial_in = sin;
    out_ready = rdy;
    @(posedge clk);
    exp_fe = (commit == 2);
    exp_ov = 1'b0;
    if (commit == 1) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1; m_data = word; m_perr = pe;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      failures++; $display("FAIL %s out_valid got=%0b exp=%0b", nm, out_valid, m_valid);
    end
    checks++;
    if (busy !== exp_busy) begin
      failures++; $display("FAIL %s busy got=%0b exp=%0b", nm, busy, exp_busy);
    end
    checks++;
    if (frame_err !== exp_fe) begin
      failures++; $display("FAIL %s frame_err got=%0b exp=%0b", nm, frame_err, exp_fe);
    end
    checks++;
    if (overrun !== exp_ov) begin
      failures++; $display("FAIL %s overrun got=%0b exp=%0b", nm, overrun, exp_ov);
    end
    if (m_valid) begin
      checks++;
      if (out_data !== m_data) begin
        failures++; $display("FAIL %s out_data got=%02h exp=%02h", nm, out_data, m_data);
      end
      checks++;
      if (out_perr !== m_perr) begin
        failures++; $display("FAIL %s out_perr got=%0b exp=%0b", nm, out_perr, m_perr);
      end
    end
  endtask

  // rdy_mode: 0 = ready low, 1 = ready high, 2 = random each cycle; rdy_stop used on the stop cycle otherwise.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int rdy_mode, input logic rdy_stop, input string nm);
    logic bits [11];
    logic r;
    bits[0] = 1'b1;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = (^d) ^ bad_par;
    bits[10] = bad_stop;
    for (int k = 0; k < 11; k++) begin
      if (rdy_mode == 2)  r = 1'($urandom_range(0, 1));
      else if (k == 10)   r = rdy_stop;
      else                r = (rdy_mode == 1);
      tick(bits[k], r, (k == 10) ? (bad_stop ? 2 : 1) : 0, d, bad_par, (k != 10), nm);
    end
  endtask

  task automatic idle(input int n, input logic rdy, input string nm);
    for (int i = 0; i < n; i++) tick(1'b0, rdy, 0, 8'h00, 1'b0, 1'b0, nm);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; serial_in = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_perr, frame_err, overrun, busy} !== 13'h0) begin
      failures++;
      $display("FAIL reset outputs got=%04h exp=0000",
               {out_data, out_valid, out_perr, frame_err, overrun, busy});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, "basic");
    checks++;
    if (out_data !== 8'hA5 || out_perr !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_word got=%02h/%0b/%0b exp=a5/0/1", out_data, out_perr, out_valid);
    end
    idle(3, 1'b0, "basic_hold");
    idle(1, 1'b1, "basic_accept");
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_cleared out_valid got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b0, 0, 1'b0, "parity");
    checks++;
    if (out_data !== 8'h01 || out_perr !== 1'b1) begin
      failures++; $display("FAIL parity_word got=%02h/%0b exp=01/1", out_data, out_perr);
    end
    idle(1, 1'b1, "parity_accept");
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0, "frame_err");
    checks++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_pulse got=%0b/%0b/%0b exp=1/0/0", frame_err, out_valid, busy);
    end
    send_frame(8'hC3, 1'b0, 1'b0, 0, 1'b0, "after_ferr");
    checks++;
    if (out_data !== 8'hC3) begin
      failures++; $display("FAIL after_ferr_word got=%02h exp=c3", out_data);
    end
    idle(1, 1'b1, "ferr_accept");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0, "b2b_first");
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b0, "b2b_overrun");
    checks++;
    if (overrun !== 1'b1 || out_data !== 8'h11) begin
      failures++; $display("FAIL b2b_overrun got=%0b/%02h exp=1/11", overrun, out_data);
    end
    idle(1, 1'b1, "b2b_accept");
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0, "b2b_first2");
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b1, "b2b_swap");
    checks++;
    if (overrun !== 1'b0 || out_data !== 8'h22 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_swap got=%0b/%02h/%0b exp=0/22/1", overrun, out_data, out_valid);
    end
    idle(1, 1'b1, "b2b_accept2");
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'hFF;
    tick(1'b1, 1'b0, 0, d, 1'b0, 1'b1, "mid_start");
    for (int i = 0; i < 4; i++) tick(d[i], 1'b0, 0, d, 1'b0, 1'b1, "mid_data");
    @(negedge clk);
    serial_in = d[4]; rst = 1'b1;
    @(posedge clk);
    m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_perr, frame_err, overrun, busy} !== 13'h0) begin
      failures++;
      $display("FAIL mid_reset outputs got=%04h exp=0000",
               {out_data, out_valid, out_perr, frame_err, overrun, busy});
    end
    @(negedge clk);
    rst = 1'b0; serial_in = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0, "post_reset");
    checks++;
    if (out_data !== 8'h5A || out_perr !== 1'b0) begin
      failures++; $display("FAIL post_reset_word got=%02h/%0b exp=5a/0", out_data, out_perr);
    end
  endtask

  task automatic test_idle();
    idle(50, 1'b0, "idle");
    checks++;
    if (out_data !== 8'h5A || out_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got=%02h/%0b/%0b exp=5a/1/0", out_data, out_valid, busy);
    end
    idle(1, 1'b1, "idle_accept");
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 2, 1'b0, "random");
      idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
